id: RTL and testbench

- Instruction-decode stage of the pipelined 32-bit processor, between instruction fetch and execute.
- Splits the fetched instruction into fields and reads two operands from a 16 x 32 register file.
- Produces one-hot operation-class controls and a 32-bit immediate, all registered into the ID/EX pipeline register.
- Accepts the write-back port from the final stage and detects load-use hazards.

---
 rtl/id_pkg.sv | 53 +++++
 rtl/id_reg_file.sv | 31 +++
 rtl/id.sv | 92 +++++++++
 tb/tb_id.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage: field positions,
// opcode classes, datapath sizes and the class decoder.
package id_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_N  = 16;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned CLS_W  = 4;

  localparam int unsigned OPC_HI   = 31;
  localparam int unsigned OPC_LO   = 25;
  localparam int unsigned IMMF_BIT = 24;
  localparam int unsigned RD_HI    = 23;
  localparam int unsigned RD_LO    = 20;
  localparam int unsigned RS_HI    = 19;
  localparam int unsigned RS_LO    = 16;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;

  localparam logic [CLS_W-1:0] OP_INT   = 4'b0000;
  localparam logic [CLS_W-1:0] OP_LOGIC = 4'b0001;
  localparam logic [CLS_W-1:0] OP_SHIFT = 4'b0010;
  localparam logic [CLS_W-1:0] OP_LDST  = 4'b0011;
  localparam logic [CLS_W-1:0] OP_BR0   = 4'b0100;
  localparam logic [CLS_W-1:0] OP_BR1   = 4'b0101;

  typedef struct packed {
    logic inte;
    logic logic_op;
    logic shift;
    logic ld;
    logic st;
    logic br;
  } ctrl_t;

  // Class is opcode[6:3]; opcode[2] separates store from load.
  function automatic ctrl_t decode_op(input logic [OPC_W-1:0] opc);
    ctrl_t c;
    c = '0;
    case (opc[6:3])
      OP_INT:         c.inte     = 1'b1;
      OP_LOGIC:       c.logic_op = 1'b1;
      OP_SHIFT:       c.shift    = 1'b1;
      OP_LDST:        if (opc[2]) c.st = 1'b1; else c.ld = 1'b1;
      OP_BR0, OP_BR1: c.br       = 1'b1;
      default:        c          = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_reg_file.sv
// 16 x 32 register file: two asynchronous read ports with write-through
// bypass, one write port, synchronous clear.
module reg_file
  import id_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] ra_a,
  input  logic [REG_AW-1:0] ra_b,
  output logic [DATA_W-1:0] rdata_a_c,
  output logic [DATA_W-1:0] rdata_b_c
);

  logic [DATA_W-1:0] mem [REG_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_N); i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Same-cycle write wins so the decoder always sees the newest value.
  assign rdata_a_c = (we && (wr_addr == ra_a)) ? wr_data : mem[ra_a];
  assign rdata_b_c = (we && (wr_addr == ra_b)) ? wr_data : mem[ra_b];

endmodule

// File: rtl/id.sv
// Instruction-decode stage: field split, operand read, class decode,
// immediate extension, load-use hazard detection and the ID/EX register.
module id
  import id_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic              stall_i,
  input  logic              wb_i,
  input  logic [3:0]        wb_r_i,
  input  logic [31:0]       wb_data_i,
  output logic [31:0]       rd_value_o,
  output logic [31:0]       rs_value_o,
  output logic [31:0]       imm_value_o,
  output logic              immf_o,
  output logic              stall_o,
  output logic              ctrl_inte_o,
  output logic              ctrl_logic_o,
  output logic              ctrl_shift_o,
  output logic              ctrl_ld_o,
  output logic              ctrl_st_o,
  output logic              ctrl_br_o
);

  logic [REG_AW-1:0] rd_idx;
  logic [REG_AW-1:0] rs_idx;
  logic [IMM_W-1:0]  imm_raw;
  logic [DATA_W-1:0] rd_rdata;
  logic [DATA_W-1:0] rs_rdata;
  logic [DATA_W-1:0] imm_ext_c;
  ctrl_t             ctrl_c;
  logic              hazard_c;
  logic [REG_AW-1:0] ex_rd_q;

  assign rd_idx  = inst_i[RD_HI:RD_LO];
  assign rs_idx  = inst_i[RS_HI:RS_LO];
  assign imm_raw = inst_i[IMM_HI:IMM_LO];

  reg_file u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .we        (wb_i),
    .wr_addr   (wb_r_i),
    .wr_data   (wb_data_i),
    .ra_a      (rs_idx),
    .ra_b      (rd_idx),
    .rdata_a_c (rs_rdata),
    .rdata_b_c (rd_rdata)
  );

  // Decode and extend; logic/shift/NOP take a zero-extended immediate.
  always_comb begin
    ctrl_c    = decode_op(inst_i[OPC_HI:OPC_LO]);
    imm_ext_c = {{(DATA_W-IMM_W){1'b0}}, imm_raw};
    if (ctrl_c.inte || ctrl_c.ld || ctrl_c.st || ctrl_c.br)
      imm_ext_c = {{(DATA_W-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};
  end

  assign hazard_c = ctrl_ld_o && ((rs_idx == ex_rd_q) || (rd_idx == ex_rd_q));
  assign stall_o  = stall_i || hazard_c;

  // ID/EX register: frozen by downstream stall, all-zero bubble on hazard.
  always_ff @(posedge clk) begin
    if (rst || (!stall_i && hazard_c)) begin
      rd_value_o   <= '0;
      rs_value_o   <= '0;
      imm_value_o  <= '0;
      immf_o       <= 1'b0;
      ctrl_inte_o  <= 1'b0;
      ctrl_logic_o <= 1'b0;
      ctrl_shift_o <= 1'b0;
      ctrl_ld_o    <= 1'b0;
      ctrl_st_o    <= 1'b0;
      ctrl_br_o    <= 1'b0;
      ex_rd_q      <= '0;
    end else if (!stall_i) begin
      rd_value_o   <= rd_rdata;
      rs_value_o   <= rs_rdata;
      imm_value_o  <= imm_ext_c;
      immf_o       <= inst_i[IMMF_BIT];
      ctrl_inte_o  <= ctrl_c.inte;
      ctrl_logic_o <= ctrl_c.logic_op;
      ctrl_shift_o <= ctrl_c.shift;
      ctrl_ld_o    <= ctrl_c.ld;
      ctrl_st_o    <= ctrl_c.st;
      ctrl_br_o    <= ctrl_c.br;
      ex_rd_q      <= rd_idx;
    end
  end

endmodule

// File: tb/tb_id.sv
// Self-checking bench for the decode stage against a behavioural model.
module tb_id;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic        stall_i;
  logic        wb_i;
  logic [3:0]  wb_r_i;
  logic [31:0] wb_data_i;
  logic [31:0] rd_value_o, rs_value_o, imm_value_o;
  logic        immf_o, stall_o;
  logic        ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o;

  int checks = 0;
  int errors = 0;

  id dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .stall_i(stall_i),
    .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i),
    .rd_value_o(rd_value_o), .rs_value_o(rs_value_o), .imm_value_o(imm_value_o),
    .immf_o(immf_o), .stall_o(stall_o),
    .ctrl_inte_o(ctrl_inte_o), .ctrl_logic_o(ctrl_logic_o), .ctrl_shift_o(ctrl_shift_o),
    .ctrl_ld_o(ctrl_ld_o), .ctrl_st_o(ctrl_st_o), .ctrl_br_o(ctrl_br_o)
  );

  always #5 clk = ~clk;

  // Model state; ctrl bit order {int, logic, shift, ld, st, br}
  logic [31:0] m_rf [16];
  logic [5:0]  m_ctrl;
  logic        m_immf;
  logic [31:0] m_rd_v, m_rs_v, m_imm_v;
  logic [3:0]  m_ld_rd;
  logic        exp_stall, got_stall;

  function automatic logic [102:0] dut_vec();
    return {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o,
            immf_o, rd_value_o, rs_value_o, imm_value_o};
  endfunction

  function automatic logic [102:0] model_vec();
    return {m_ctrl, m_immf, m_rd_v, m_rs_v, m_imm_v};
  endfunction

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic immf,
                                          input logic [3:0] rd, input logic [3:0] rs,
                                          input logic [15:0] imm);
    return {opc, immf, rd, rs, imm};
  endfunction

  // Advance one clock: predict the next ID/EX contents from the current inputs.
  task automatic tick();
    logic [6:0]  opc;
    logic [3:0]  rd, rs;
    logic [15:0] imm;
    int          cls;
    logic        haz, sx;
    logic [5:0]  c;
    #1;
    opc = inst_i[31:25]; rd = inst_i[23:20]; rs = inst_i[19:16]; imm = inst_i[15:0];
    haz = m_ctrl[2] && (rs == m_ld_rd || rd == m_ld_rd);
    exp_stall = stall_i | haz;
    got_stall = stall_o;
    cls = int'(opc) / 8;
    if (cls == 0) c = 6'b100000;
    else if (cls == 1) c = 6'b010000;
    else if (cls == 2) c = 6'b001000;
    else if (cls == 3) c = opc[2] ? 6'b000010 : 6'b000100;
    else if (cls == 4 || cls == 5) c = 6'b000001;
    else c = 6'b000000;
    sx = (cls == 0 || cls == 3 || cls == 4 || cls == 5);
    if (rst) begin
      m_ctrl = '0; m_immf = 0; m_rd_v = 0; m_rs_v = 0; m_imm_v = 0; m_ld_rd = 0;
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
    end else begin
      if (!stall_i) begin
        if (haz) begin
          m_ctrl = '0; m_immf = 0; m_rd_v = 0; m_rs_v = 0; m_imm_v = 0; m_ld_rd = 0;
        end else begin
          m_ctrl  = c;
          m_immf  = inst_i[24];
          m_rd_v  = (wb_i && wb_r_i == rd) ? wb_data_i : m_rf[rd];
          m_rs_v  = (wb_i && wb_r_i == rs) ? wb_data_i : m_rf[rs];
          m_imm_v = sx ? {{16{imm[15]}}, imm} : {16'h0, imm};
          m_ld_rd = rd;
        end
      end
      if (wb_i) m_rf[wb_r_i] = wb_data_i;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall_i = 0; wb_i = 0; wb_r_i = 0; wb_data_i = 0;
    for (int i = 0; i < 2; i++) begin
      inst_i = $urandom;
      tick();
    end
    checks++;
    if (dut_vec() !== 103'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
    rst = 0;
    for (int r = 0; r < 16; r++) begin
      inst_i = mk_inst(7'h7F, 1'b0, 4'(r), 4'(15 - r), 16'h0);
      tick();
      checks++;
      if (rd_value_o !== 32'h0 || rs_value_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_regs r%0d: got rd=%h rs=%h want 0", r, rd_value_o, rs_value_o);
      end
    end
  endtask

  task automatic test_write_read();
    wb_i = 1; wb_r_i = 3; wb_data_i = 32'h0000_0003; inst_i = mk_inst(7'h7F, 0, 0, 0, 0);
    tick();
    wb_r_i = 9; wb_data_i = 32'hDEAD_BEEF;
    tick();
    wb_i = 0;
    inst_i = mk_inst(7'h00, 1'b1, 4'd3, 4'd9, 16'h8001);
    tick();
    checks++;
    if (dut_vec() !== {6'b100000, 1'b1, 32'h3, 32'hDEADBEEF, 32'hFFFF8001}) begin
      errors++;
      $display("FAIL write_read: got %h want ctrl=100000 immf=1 rd=3 rs=deadbeef imm=ffff8001", dut_vec());
    end
  endtask

  task automatic test_class_sweep();
    logic [6:0]  opcs [7];
    logic [5:0]  flags [7];
    logic [31:0] imms [7];
    opcs  = '{7'h08, 7'h10, 7'h18, 7'h1C, 7'h20, 7'h28, 7'h7F};
    flags = '{6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001, 6'b000001, 6'b000000};
    imms  = '{32'h8001, 32'h8001, 32'hFFFF8001, 32'hFFFF8001, 32'hFFFF8001, 32'hFFFF8001, 32'h8001};
    for (int i = 0; i < 7; i++) begin
      inst_i = mk_inst(opcs[i], 1'b0, 4'(i + 1), 4'(i + 8), 16'h8001);
      tick();
      checks++;
      if ({ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o} !== flags[i]
          || imm_value_o !== imms[i]) begin
        errors++;
        $display("FAIL class_sweep op=%h: got ctrl=%b imm=%h want ctrl=%b imm=%h", opcs[i],
                 {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o},
                 imm_value_o, flags[i], imms[i]);
      end
    end
  endtask

  task automatic test_bypass();
    wb_i = 1; wb_r_i = 5; wb_data_i = 32'h1234_5678;
    inst_i = mk_inst(7'h7F, 1'b0, 4'd6, 4'd5, 16'h0);
    tick();
    wb_i = 0;
    checks++;
    if (rs_value_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL bypass: got rs=%h want 12345678", rs_value_o);
    end
  endtask

  task automatic test_load_use();
    int stalls;
    inst_i = mk_inst(7'h18, 1'b0, 4'd4, 4'd0, 16'h0010);
    tick();
    inst_i = mk_inst(7'h00, 1'b1, 4'd8, 4'd4, 16'h0001);
    stalls = 0;
    tick();
    if (got_stall) stalls++;
    checks++;
    if ({ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o, immf_o} !== 7'b0) begin
      errors++;
      $display("FAIL load_use_bubble: got ctrl=%b immf=%b want 0", {ctrl_inte_o, ctrl_logic_o,
               ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o}, immf_o);
    end
    tick();
    if (got_stall) stalls++;
    checks++;
    if (stalls != 1 || ctrl_inte_o !== 1'b1 || immf_o !== 1'b1) begin
      errors++;
      $display("FAIL load_use_resume: got stalls=%0d inte=%b want stalls=1 inte=1", stalls, ctrl_inte_o);
    end
    inst_i = mk_inst(7'h18, 1'b0, 4'd4, 4'd0, 16'h0010);
    tick();
    inst_i = mk_inst(7'h00, 1'b0, 4'd8, 4'd7, 16'h0001);
    tick();
    checks++;
    if (got_stall !== 1'b0 || ctrl_inte_o !== 1'b1) begin
      errors++;
      $display("FAIL load_no_hazard: got stall=%b inte=%b want 0/1", got_stall, ctrl_inte_o);
    end
  endtask

  task automatic test_stall_i();
    logic [102:0] frozen;
    logic [31:0]  val;
    inst_i = mk_inst(7'h08, 1'b1, 4'd1, 4'd2, 16'hABCD);
    tick();
    frozen = dut_vec();
    val = $urandom;
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      inst_i = $urandom;
      wb_i = (i == 0); wb_r_i = 4'd10; wb_data_i = val;
      tick();
      checks++;
      if (dut_vec() !== frozen || got_stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_freeze cyc%0d: got %h stall=%b want %h stall=1", i, dut_vec(), got_stall, frozen);
      end
    end
    stall_i = 0; wb_i = 0;
    inst_i = mk_inst(7'h7F, 1'b0, 4'd11, 4'd10, 16'h0);
    tick();
    checks++;
    if (rs_value_o !== val) begin
      errors++;
      $display("FAIL stall_wb_release: got rs=%h want %h", rs_value_o, val);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      stall_i   = ($urandom_range(0, 7) == 0);
      wb_i      = $urandom_range(0, 1);
      wb_r_i    = 4'($urandom_range(0, 15));
      wb_data_i = $urandom;
      inst_i    = {7'($urandom_range(0, 47)), 1'($urandom), 4'($urandom_range(0, 5)),
                   4'($urandom_range(0, 5)), 16'($urandom)};
      tick();
      checks++;
      if (dut_vec() !== model_vec() || got_stall !== exp_stall) begin
        errors++;
        $display("FAIL random cyc%0d: got %h stall=%b want %h stall=%b", i, dut_vec(), got_stall,
                 model_vec(), exp_stall);
      end
    end
    rst = 0; stall_i = 0; wb_i = 0;
  endtask

  initial begin
    rst = 1; inst_i = 0; stall_i = 0; wb_i = 0; wb_r_i = 0; wb_data_i = 0;
    m_ctrl = '0; m_immf = 0; m_rd_v = 0; m_rs_v = 0; m_imm_v = 0; m_ld_rd = 0;
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_class_sweep();
    test_bypass();
    test_load_use();
    test_stall_i();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
